// File: rtl/prime_filter_ctrl_if.sv
// ROM, prime-checker and RAM buses between prime_filter_ctrl and its datapath.
// master = controller side, slave = ROM/checker/RAM side.
interface prime_filter_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ROM_AW = 4,
    parameter int RAM_AW = 4
);
    logic [ROM_AW-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              chk_start;
    logic [DATA_W-1:0] chk_value;
    logic              chk_done;
    logic              chk_prime;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output rom_addr,
        input  rom_data,
        output chk_start,
        output chk_value,
        input  chk_done,
        input  chk_prime,
        output ram_we,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  chk_start,
        input  chk_value,
        output chk_done,
        output chk_prime,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/prime_filter_ctrl.sv
// Walks N_ITEMS ROM entries through an external prime checker and buffers primes in RAM.
// Define PRIME_FILTER_MAX_SCAN_EN to add the post-run SCAN pass that computes max_prime.
module prime_filter_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ROM_AW  = 4,
    parameter int RAM_AW  = 4,
    parameter int N_ITEMS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    prime_filter_ctrl_if.master bus,
    output logic [RAM_AW:0]     prime_count,
    output logic [DATA_W-1:0]   max_prime,
    output logic                overflow,
    output logic                busy,
    output logic                done,
    output logic                disp_sel
);
    localparam logic [RAM_AW:0]   CAPACITY  = {1'b1, {RAM_AW{1'b0}}};
    localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(N_ITEMS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_START,
        ST_WAIT,
        ST_WRITE,
`ifdef PRIME_FILTER_MAX_SCAN_EN
        ST_SCAN,
`endif
        ST_FINISH
    } state_t;

    state_t            state_reg, state_next;
    logic [ROM_AW-1:0] rom_addr_reg, rom_addr_next;
    logic [DATA_W-1:0] chk_value_reg, chk_value_next;
    logic [RAM_AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [RAM_AW:0]   count_reg, count_next;
    logic              overflow_reg, overflow_next;
    logic              advance;
    logic              buf_full;
    logic              chk_start_c;
    logic              ram_we_c;
    logic              busy_c;
    logic              done_c;
    logic              disp_sel_c;
`ifdef PRIME_FILTER_MAX_SCAN_EN
    logic [RAM_AW-1:0] scan_ptr_reg, scan_ptr_next;
    logic [DATA_W-1:0] max_reg, max_next;
    logic              scan_last;
`endif

    assign buf_full = (count_reg == CAPACITY);
`ifdef PRIME_FILTER_MAX_SCAN_EN
    assign scan_last = (({1'b0, scan_ptr_reg} + 1'b1) == count_reg);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            rom_addr_reg  <= '0;
            chk_value_reg <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
`ifdef PRIME_FILTER_MAX_SCAN_EN
            scan_ptr_reg  <= '0;
            max_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            rom_addr_reg  <= rom_addr_next;
            chk_value_reg <= chk_value_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
`ifdef PRIME_FILTER_MAX_SCAN_EN
            scan_ptr_reg  <= scan_ptr_next;
            max_reg       <= max_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        rom_addr_next  = rom_addr_reg;
        chk_value_next = chk_value_reg;
        wr_ptr_next    = wr_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
`ifdef PRIME_FILTER_MAX_SCAN_EN
        scan_ptr_next  = scan_ptr_reg;
        max_next       = max_reg;
`endif
        advance     = 1'b0;
        chk_start_c = 1'b0;
        ram_we_c    = 1'b0;
        busy_c      = 1'b1;
        done_c      = 1'b0;
        disp_sel_c  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                busy_c = 1'b0;
                // Previous results stay visible until the next run is requested.
                if (start) begin
                    rom_addr_next = '0;
                    wr_ptr_next   = '0;
                    count_next    = '0;
                    overflow_next = 1'b0;
`ifdef PRIME_FILTER_MAX_SCAN_EN
                    scan_ptr_next = '0;
                    max_next      = '0;
`endif
                    state_next    = ST_READ;
                end
            end
            ST_READ: begin
                disp_sel_c     = 1'b1;
                chk_value_next = bus.rom_data;
                state_next     = ST_START;
            end
            ST_START: begin
                disp_sel_c  = 1'b1;
                chk_start_c = 1'b1;
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                disp_sel_c = 1'b1;
                if (bus.chk_done) begin
                    if (bus.chk_prime && !buf_full) begin
                        state_next = ST_WRITE;
                    end else begin
                        advance = 1'b1;
                        if (bus.chk_prime) begin
                            overflow_next = 1'b1;
                        end
                    end
                end
            end
            ST_WRITE: begin
                disp_sel_c  = 1'b1;
                ram_we_c    = 1'b1;
                wr_ptr_next = wr_ptr_reg + 1'b1;
                count_next  = count_reg + 1'b1;
                advance     = 1'b1;
            end
`ifdef PRIME_FILTER_MAX_SCAN_EN
            ST_SCAN: begin
                if (bus.ram_rdata > max_reg) begin
                    max_next = bus.ram_rdata;
                end
                if (scan_last) begin
                    state_next = ST_FINISH;
                end else begin
                    scan_ptr_next = scan_ptr_reg + 1'b1;
                end
            end
`endif
            ST_FINISH: begin
                done_c     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // count_next already includes a WRITE-cycle increment, so an empty buffer skips SCAN.
        if (advance) begin
            if (rom_addr_reg == LAST_ADDR) begin
`ifdef PRIME_FILTER_MAX_SCAN_EN
                state_next = (count_next != '0) ? ST_SCAN : ST_FINISH;
`else
                state_next = ST_FINISH;
`endif
            end else begin
                rom_addr_next = rom_addr_reg + 1'b1;
                state_next    = ST_READ;
            end
        end
    end

    assign bus.rom_addr  = rom_addr_reg;
    assign bus.chk_start = chk_start_c;
    assign bus.chk_value = chk_value_reg;
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_wdata = chk_value_reg;
`ifdef PRIME_FILTER_MAX_SCAN_EN
    assign bus.ram_addr  = (state_reg == ST_SCAN) ? scan_ptr_reg : wr_ptr_reg;
    assign max_prime     = max_reg;
`else
    logic unused_rdata;
    assign unused_rdata  = ^bus.ram_rdata;
    assign bus.ram_addr  = wr_ptr_reg;
    assign max_prime     = '0;
`endif

    assign prime_count = count_reg;
    assign overflow    = overflow_reg;
    assign busy        = busy_c;
    assign done        = done_c;
    assign disp_sel    = disp_sel_c;
endmodule

// File: tb/tb_prime_filter_ctrl.sv
// Directed bench: two controllers (16-deep and 4-deep RAM) share one ROM and a 3-cycle checker model.
module tb_prime_filter_ctrl;
    localparam int DATA_W  = 8;
    localparam int ROM_AW  = 4;
    localparam int N_ITEMS = 8;
`ifdef PRIME_FILTER_MAX_SCAN_EN
    localparam int EXP_MAX   = 13;
    localparam int DONE_A    = 51;
    localparam int DONE_B    = 49;
`else
    localparam int EXP_MAX   = 0;
    localparam int DONE_A    = 46;
    localparam int DONE_B    = 45;
`endif
    localparam int DONE_ZERO = 41;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic ram_clr = 1'b0;
    logic noise_en = 1'b0;
    always #5 clk = ~clk;

    prime_filter_ctrl_if #(.DATA_W(DATA_W), .ROM_AW(ROM_AW), .RAM_AW(4)) bus_a ();
    prime_filter_ctrl_if #(.DATA_W(DATA_W), .ROM_AW(ROM_AW), .RAM_AW(2)) bus_b ();

    logic [4:0] cnt_a;
    logic [2:0] cnt_b;
    logic [7:0] max_a, max_b;
    logic ovf_a, ovf_b, busy_a, busy_b, done_a, done_b, disp_a, disp_b;

    prime_filter_ctrl #(.DATA_W(DATA_W), .ROM_AW(ROM_AW), .RAM_AW(4), .N_ITEMS(N_ITEMS)) dut_a (
        .clk(clk), .reset(reset), .start(start), .bus(bus_a),
        .prime_count(cnt_a), .max_prime(max_a), .overflow(ovf_a),
        .busy(busy_a), .done(done_a), .disp_sel(disp_a)
    );
    prime_filter_ctrl #(.DATA_W(DATA_W), .ROM_AW(ROM_AW), .RAM_AW(2), .N_ITEMS(N_ITEMS)) dut_b (
        .clk(clk), .reset(reset), .start(start), .bus(bus_b),
        .prime_count(cnt_b), .max_prime(max_b), .overflow(ovf_b),
        .busy(busy_b), .done(done_b), .disp_sel(disp_b)
    );

    logic [7:0] rom [16];
    logic [7:0] ram_a [16];
    logic [7:0] ram_b [4];
    logic [7:0] exp_ram [5];

    assign bus_a.rom_data  = rom[bus_a.rom_addr];
    assign bus_b.rom_data  = rom[bus_b.rom_addr];
    assign bus_a.ram_rdata = ram_a[bus_a.ram_addr];
    assign bus_b.ram_rdata = ram_b[bus_b.ram_addr];

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) ram_a[i] <= '0;
            for (int i = 0; i < 4; i++) ram_b[i] <= '0;
        end else begin
            if (bus_a.ram_we) ram_a[bus_a.ram_addr] <= bus_a.ram_wdata;
            if (bus_b.ram_we) ram_b[bus_b.ram_addr] <= bus_b.ram_wdata;
        end
    end

    function automatic logic is_prime(input logic [7:0] v);
        if (v < 8'd2) return 1'b0;
        for (int d = 2; d * d <= int'(v); d++) begin
            if (int'(v) % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Checker model: chk_done rises on the third cycle after the chk_start cycle.
    logic [1:0] ck_cnt_a = '0, ck_cnt_b = '0;
    logic ck_done_a = 1'b0, ck_done_b = 1'b0, ck_prime_a = 1'b0, ck_prime_b = 1'b0;
    always @(posedge clk) begin
        if (bus_a.chk_start) begin
            ck_cnt_a <= 2'd2; ck_done_a <= 1'b0; ck_prime_a <= is_prime(bus_a.chk_value);
        end else begin
            ck_done_a <= (ck_cnt_a == 2'd1);
            if (ck_cnt_a != 2'd0) ck_cnt_a <= ck_cnt_a - 2'd1;
        end
        if (bus_b.chk_start) begin
            ck_cnt_b <= 2'd2; ck_done_b <= 1'b0; ck_prime_b <= is_prime(bus_b.chk_value);
        end else begin
            ck_done_b <= (ck_cnt_b == 2'd1);
            if (ck_cnt_b != 2'd0) ck_cnt_b <= ck_cnt_b - 2'd1;
        end
    end

    // Spurious prime results injected only in START/WRITE, where the controller must ignore them.
    logic noise_a, noise_b;
    assign noise_a = noise_en & (bus_a.chk_start | bus_a.ram_we);
    assign noise_b = noise_en & (bus_b.chk_start | bus_b.ram_we);
    assign bus_a.chk_done  = ck_done_a | noise_a;
    assign bus_a.chk_prime = ck_prime_a | noise_a;
    assign bus_b.chk_done  = ck_done_b | noise_b;
    assign bus_b.chk_prime = ck_prime_b | noise_b;

    int n_checks = 0;
    int n_pass = 0;
    int done_idx_a, done_idx_b, ndone_a, ndone_b, nwr_a, nwr_b;
    int run_no = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic ram_clear();
        @(negedge clk); ram_clr = 1'b1;
        @(negedge clk); ram_clr = 1'b0;
    endtask

    // Fixed 80-cycle window from the start edge; idx 1 is the first READ cycle.
    task automatic run_once(input logic with_noise);
        noise_en = with_noise;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        done_idx_a = 0; done_idx_b = 0; ndone_a = 0; ndone_b = 0; nwr_a = 0; nwr_b = 0;
        for (int idx = 1; idx <= 80; idx++) begin
            if (done_a) begin ndone_a++; if (done_idx_a == 0) done_idx_a = idx; end
            if (done_b) begin ndone_b++; if (done_idx_b == 0) done_idx_b = idx; end
            if (bus_a.ram_we) nwr_a++;
            if (bus_b.ram_we) nwr_b++;
            start = (with_noise && idx >= 10 && idx <= 12) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        noise_en = 1'b0;
        run_no++;
        $display("run %0d: a count=%0d max=%0d ovf=%0d done@%0d writes=%0d | b count=%0d max=%0d ovf=%0d done@%0d writes=%0d",
                 run_no, cnt_a, max_a, ovf_a, done_idx_a, nwr_a, cnt_b, max_b, ovf_b, done_idx_b, nwr_b);
    endtask

    task automatic check_main_run(input string tag);
        check_eq({tag, "_cnt_a"}, 32'(cnt_a), 5);
        check_eq({tag, "_max_a"}, 32'(max_a), EXP_MAX);
        check_eq({tag, "_ovf_a"}, 32'(ovf_a), 0);
        check_eq({tag, "_ndone_a"}, ndone_a, 1);
        check_eq({tag, "_done_at_a"}, done_idx_a, DONE_A);
        check_eq({tag, "_writes_a"}, nwr_a, 5);
        check_eq({tag, "_busy_a"}, 32'(busy_a), 0);
        check_eq({tag, "_rom_addr_a"}, 32'(bus_a.rom_addr), N_ITEMS - 1);
        for (int i = 0; i < 5; i++) check_eq($sformatf("%s_ram_a%0d", tag, i), 32'(ram_a[i]), 32'(exp_ram[i]));
        check_eq({tag, "_cnt_b"}, 32'(cnt_b), 4);
        check_eq({tag, "_max_b"}, 32'(max_b), EXP_MAX);
        check_eq({tag, "_ovf_b"}, 32'(ovf_b), 1);
        check_eq({tag, "_ndone_b"}, ndone_b, 1);
        check_eq({tag, "_done_at_b"}, done_idx_b, DONE_B);
        for (int i = 0; i < 4; i++) check_eq($sformatf("%s_ram_b%0d", tag, i), 32'(ram_b[i]), 32'(exp_ram[i]));
    endtask

    initial begin
        logic found;
        int   nw;
        exp_ram[0] = 8'd2; exp_ram[1] = 8'd5; exp_ram[2] = 8'd11; exp_ram[3] = 8'd13; exp_ram[4] = 8'd7;
        for (int i = 0; i < 16; i++) rom[i] = 8'd0;
        rom[0] = 8'd2; rom[1] = 8'd4; rom[2] = 8'd5;  rom[3] = 8'd9;
        rom[4] = 8'd11; rom[5] = 8'd13; rom[6] = 8'd1; rom[7] = 8'd7;

        // Reset state
        ram_clr = 1'b1;
        #12;
        check_eq("rst_busy", 32'(busy_a), 0);
        check_eq("rst_done", 32'(done_a), 0);
        check_eq("rst_disp", 32'(disp_a), 0);
        check_eq("rst_cnt", 32'(cnt_a), 0);
        check_eq("rst_chk_start", 32'(bus_a.chk_start), 0);
        check_eq("rst_ram_we", 32'(bus_a.ram_we), 0);
        check_eq("rst_chk_value", 32'(bus_a.chk_value), 0);
        @(negedge clk); reset = 1'b1; ram_clr = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_busy", 32'(busy_a), 0);
        check_eq("idle_rom_addr", 32'(bus_a.rom_addr), 0);
        check_eq("idle_max", 32'(max_a), 0);
        check_eq("idle_ovf", 32'(ovf_b), 0);

        // Main run, then the same run with start and chk_done noise
        run_once(1'b0);
        check_main_run("run1");
        check_eq("run1_chk_value", 32'(bus_a.chk_value), 7);
        ram_clear();
        run_once(1'b1);
        check_main_run("noise");

        // ROM of all 4s: nothing stored, SCAN skipped
        for (int i = 0; i < N_ITEMS; i++) rom[i] = 8'd4;
        ram_clear();
        run_once(1'b0);
        check_eq("zero_cnt_a", 32'(cnt_a), 0);
        check_eq("zero_max_a", 32'(max_a), 0);
        check_eq("zero_ovf_b", 32'(ovf_b), 0);
        check_eq("zero_writes_a", nwr_a, 0);
        check_eq("zero_done_at_a", done_idx_a, DONE_ZERO);
        check_eq("zero_ndone_a", ndone_a, 1);

        // Reset during the third WRITE, then a clean run
        rom[0] = 8'd2; rom[1] = 8'd4; rom[2] = 8'd5;  rom[3] = 8'd9;
        rom[4] = 8'd11; rom[5] = 8'd13; rom[6] = 8'd1; rom[7] = 8'd7;
        ram_clear();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        found = 1'b0;
        nw = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (bus_a.ram_we) begin
                nw++;
                if (nw == 3) found = 1'b1;
            end
            if (!found) begin @(posedge clk); #1; end
        end
        check_eq("rst_mid_third_write_seen", 32'(found), 1);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_mid_busy", 32'(busy_a), 0);
        check_eq("rst_mid_ram_we", 32'(bus_a.ram_we), 0);
        check_eq("rst_mid_cnt", 32'(cnt_a), 0);
        check_eq("rst_mid_rom_addr", 32'(bus_a.rom_addr), 0);
        check_eq("rst_mid_disp", 32'(disp_a), 0);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mid_ram1_kept", 32'(ram_a[1]), 5);
        check_eq("rst_mid_ram2_unwritten", 32'(ram_a[2]), 0);
        run_once(1'b0);
        check_main_run("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prime_filter_ctrl.md
# prime_filter_ctrl

Parametrised controller for the prime-filter datapath. It walks a ROM of N_ITEMS entries, hands each value to an external prime checker, and writes every prime into a RAM buffer with its own write pointer and count. It can optionally scan the buffer afterwards for the largest prime. Unlike the first-generation controller, it owns its address counters and has parametrised widths and item count. It also reports RAM overflow and signals end of run with a done pulse.

## Interface
- DATA_W, 8, width of ROM/RAM data and checker value
- ROM_AW, 4, ROM address width
- RAM_AW, 4, RAM address width; buffer depth = 2**RAM_AW
- N_ITEMS, 16, ROM entries scanned, addresses 0..N_ITEMS-1; legal range 1..2**ROM_AW
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces IDLE immediately
- start  in  1  begin a run; sampled in IDLE only
- rom_addr  out  ROM_AW  ROM read address; ROM read is combinational
- rom_data  in  DATA_W  ROM data for rom_addr
- chk_start  out  1  one-cycle pulse to the checker
- chk_value  out  DATA_W  registered value under test
- chk_done  in  1  checker result valid
- chk_prime  in  1  1 = prime; qualified by chk_done
- ram_we  out  1  RAM write enable
- ram_addr  out  RAM_AW  write pointer in WRITE; scan pointer in SCAN
- ram_wdata  out  DATA_W  equals chk_value
- ram_rdata  in  DATA_W  combinational RAM read data
- prime_count  out  RAM_AW+1  primes stored this run
- max_prime  out  DATA_W  largest stored prime
- overflow  out  1  sticky; a prime was dropped because the RAM was full
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- disp_sel  out  1  1 during READ/START/WAIT/WRITE

## Operation
- States: IDLE, READ, START, WAIT, WRITE, SCAN (macro only), FINISH.
- IDLE: busy=0. If start=1, clear rom_addr, wr_ptr, scan_ptr, prime_count, max_prime and overflow, then go to READ. Outputs and buffer contents from the previous run are held until start.
- READ: chk_value <= rom_data. Next state is START.
- START: chk_start=1. Next state is WAIT.
- WAIT: while chk_done=0, stay in WAIT. When chk_done=1:
  - prime and prime_count < 2**RAM_AW: go to WRITE.
  - prime and buffer full: set overflow=1 and advance.
  - not prime: advance.
- WRITE: ram_we=1, ram_addr=wr_ptr. wr_ptr and prime_count each increment by 1. Then advance.
- Advance: if rom_addr == N_ITEMS-1, go to SCAN (or to FINISH without the macro). Otherwise increment rom_addr and go to READ.
- SCAN: ram_addr=scan_ptr. If ram_rdata > max_prime, load max_prime. When scan_ptr == prime_count-1, go to FINISH; otherwise increment scan_ptr. If prime_count=0, SCAN is skipped and the FSM goes straight to FINISH.
- FINISH: done=1. Next state is IDLE.
- start is ignored while busy=1.
- chk_done and chk_prime are ignored outside WAIT.
- prime_count saturates at 2**RAM_AW. wr_ptr wraps, but is never used once full.
- Comparison is unsigned over DATA_W bits.
- rom_addr never exceeds N_ITEMS-1.

## Timing
- All outputs are 0 during reset and in the first IDLE cycle after reset.
- Control outputs are Moore-decoded from the state register; counters and data are registered.
- Per ROM entry: READ(1) + START(1) + WAIT(k≥1, including the chk_done cycle) + WRITE(1 if stored).
- chk_value is stable from the START cycle until the next READ.
- SCAN takes prime_count cycles. max_prime is final in the cycle after the last SCAN cycle, which is the FINISH cycle.
- done coincides with FINISH. busy falls the following cycle.
- The earliest possible restart is start sampled in the first IDLE cycle after FINISH.
- Reset asserted mid-run: the FSM enters IDLE asynchronously, all counters and outputs clear, ram_we drops immediately, and RAM contents are left untouched.

## Configuration
- PRIME_FILTER_MAX_SCAN_EN defined: the SCAN state and scan_ptr exist, and max_prime is computed as specified.
- Undefined: no SCAN state, max_prime is tied to 0, and the FSM goes from the last advance directly to FINISH. The run is prime_count cycles shorter.

## Test plan
- N_ITEMS=8, ROM={2,4,5,9,11,13,1,7}, checker done after 3 cycles, run started -> RAM[0..4]={2,5,11,13,7}, prime_count=5, max_prime=13, overflow=0, one done pulse.
- Same ROM with RAM_AW=2 -> RAM[0..3]={2,5,11,13}, 7 dropped, prime_count=4, overflow=1, max_prime=13.
- ROM all 4 -> no ram_we, prime_count=0, SCAN skipped, done 1 cycle after last WAIT, max_prime=0.
- start pulsed while busy, and chk_done pulsed outside WAIT -> no effect on state, counters or writes.
- reset=0 during the 3rd WRITE -> busy=0 and ram_we=0 immediately. A later start gives a clean run with results identical to the first scenario.
- Macro undefined, first scenario's ROM -> max_prime=0, done arrives 5 cycles earlier than with the macro.
